bp_initiator: RTL and testbench
===============================

# bp_initiator

Host-side initiator for the BytePipe register protocol: it converts a register request (read or write, address, burst length) into the command byte stream a BytePipe register responder expects, and collects the response bytes. It sits between on-chip control logic (self-test sequencer, bridge from another host link) and any BytePipe responder. It supports single and burst transactions, streams write and read data with full backpressure, and times out when a responder never answers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, idle cycles allowed while awaiting a response byte before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready; high only in IDLE
- i_req_wr  in  1  1=write, 0=read
- i_req_addr  in  7  register address
- i_req_len  in  8  burst length L; the request transfers L+1 data bytes
- i_wr_data  in  8  write data stream
- i_wr_valid  in  1  write data valid
- o_wr_ready  out  1  write data ready
- o_rd_data  out  8  read data stream
- o_rd_valid  out  1  read data valid
- i_rd_ready  in  1  read data ready
- o_done  out  1  one-cycle pulse on transaction completion
- o_done_data  out  8  last response byte of the completed transaction (write: read-back byte; read: final data byte)
- o_timeout  out  1  one-cycle pulse on abort
- o_bp_data  out  8  BytePipe bytes to responder
- o_bp_valid  out  1  valid toward responder
- i_bp_ready  in  1  ready from responder
- i_bp_data  in  8  BytePipe bytes from responder
- i_bp_valid  in  1  valid from responder
- o_bp_ready  out  1  ready toward responder

## Operation
- Protocol facts: command byte = {wr, addr[6:0]}. A write is one command byte plus one data byte; the responder then returns one byte. A read is one command byte; the responder returns one byte. Writing value L to address 0 arms a burst: the next command to a nonzero address transfers L+1 data bytes. A burst write returns one byte after its final data byte.
- Effective length: Le = (addr==0) ? 0 : L. Address-0 requests are always single transfers.
- FSM states: IDLE, SETUP_CMD, SETUP_LEN, SETUP_RSP, CMD, WR_DATA, RD_DATA, WR_RSP.
- IDLE: o_req_ready=1. On accept, capture wr, addr, Le and set cnt=Le. Next state is SETUP_CMD if Le!=0, else CMD. o_bp_ready=1; stray bytes are accepted and discarded.
- SETUP_CMD: drive 0x80 with valid=1, and advance on i_bp_ready.
- SETUP_LEN: drive Le, and advance on i_bp_ready.
- SETUP_RSP: o_bp_ready=1; discard one byte, then go to CMD.
- CMD: drive {wr, addr} with valid=1. On handshake, go to WR_DATA if wr, else RD_DATA.
- WR_DATA: pass-through, with o_bp_data=i_wr_data, o_bp_valid=i_wr_valid, o_wr_ready=i_bp_ready. Each handshake decrements cnt. The handshake at cnt==0 moves to WR_RSP.
- WR_RSP: o_bp_ready=1. On the byte, pulse o_done, load o_done_data, and go to IDLE.
- RD_DATA: pass-through, with o_rd_data=i_bp_data, o_rd_valid=i_bp_valid, o_bp_ready=i_rd_ready. Each handshake decrements cnt. The handshake at cnt==0 pulses o_done, loads o_done_data, and goes to IDLE.
- Outside pass-through states, o_wr_ready=0 and o_rd_valid=0. o_bp_valid=0 in IDLE and in the response states.
- Timeout: the counter clears on state entry and on any i_bp handshake. It increments in SETUP_RSP, RD_DATA and WR_RSP while no byte arrives. When it reaches TIMEOUT_CYCLES, pulse o_timeout (no o_done) and go to IDLE. In RD_DATA, stalls from i_rd_ready=0 while i_bp_valid=1 do not count.

## Timing
- Reset values: state IDLE, o_done=0, o_timeout=0, o_done_data=0x00, cnt=0, o_bp_valid=0, o_rd_valid=0, o_wr_ready=0, o_req_ready=1.
- First command byte is valid in the cycle after request accept.
- Bytes sent, for write: 1+(Le+1), plus 2 if Le>0. For read: 1, plus 2 if Le>0.
- o_done and o_timeout are registered and asserted in the cycle after the final handshake. o_req_ready rises in that same cycle, so back-to-back requests lose no more than one cycle.
- o_done_data holds until the next completion.
- All stream paths are combinational pass-through, with no added latency and no buffering.
- Reset mid-transaction returns to IDLE immediately. Any armed burst left in the responder is the system's responsibility.

## Test plan
- Single write, addr 0x09, data 0x05, responder returns 0x00: o_bp bytes 0x89, 0x05. o_done pulses once, with o_done_data=0x00.
- Single read, addr 0x04, with the responder delaying 20 cycles then sending 0x20: o_bp byte 0x04, o_rd_data=0x20 for one handshake, o_done=1, no timeout.
- Burst write, addr 0x0A, L=3, data 11,22,33,44, i_bp_ready toggling every cycle: bytes 0x80, 0x03, [ack discarded], 0x8A, 11, 22, 33, 44, then WR_RSP and o_done.
- Burst read, addr 0x01, L=2, i_rd_ready low for 5 cycles mid-stream: exactly 3 bytes delivered in order, o_bp_ready tracks i_rd_ready, no timeout during the stall.
- Timeout with TIMEOUT_CYCLES=16, read with a silent responder: o_timeout pulses 16 cycles after the command handshake, o_done is never asserted, and the block returns to IDLE.
- i_rst_n asserted mid-way through WR_DATA of an L=5 write: o_bp_valid is 0 immediately, and o_req_ready=1 after reset release.

Source files
------------

// File: rtl/bp_initiator.sv
// BytePipe register initiator: turns a read/write/burst request into command bytes and collects responses.
// Latency: first command byte valid the cycle after request accept; done/timeout pulse one cycle after final byte.
// Backpressure: data streams are combinational pass-through both ways; responder silence aborts after TIMEOUT_CYCLES.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_req_* / o_req_ready            request: wr flag, 7-bit address, burst length L (L+1 data bytes)
//   i_wr_* / o_wr_ready              write data stream toward the responder
//   o_rd_* / i_rd_ready              read data stream from the responder
//   o_done, o_done_data, o_timeout   completion pulse with last response byte, abort pulse
//   o_bp_* / i_bp_ready              BytePipe bytes to responder
//   i_bp_* / o_bp_ready              BytePipe bytes from responder
module bp_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_wr,
    input  logic [6:0] i_req_addr,
    input  logic [7:0] i_req_len,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    output logic       o_done,
    output logic [7:0] o_done_data,
    output logic       o_timeout,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP_CMD,
        S_SETUP_LEN,
        S_SETUP_RSP,
        S_CMD,
        S_WR_DATA,
        S_RD_DATA,
        S_WR_RSP
    } state_t;

    // Wait counter is wide enough to hold TIMEOUT_CYCLES-1; abort fires on the cycle it would reach TIMEOUT_CYCLES.
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    state_t          r_state;
    logic            r_wr;
    logic [6:0]      r_addr;
    logic [7:0]      r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_done;
    logic            r_timeout;
    logic [7:0]      r_done_data;

    logic [7:0]      w_le;
    logic            w_bp_in_hs;
    logic            w_bp_out_hs;
    logic            w_wait;
    logic            w_to_hit;

    // Address 0 is the burst-length register itself, so it is never bursted.
    assign w_le        = (i_req_addr == 7'd0) ? 8'd0 : i_req_len;
    assign w_bp_in_hs  = i_bp_valid & o_bp_ready;
    assign w_bp_out_hs = o_bp_valid & i_bp_ready;
    assign w_wait      = (r_state == S_SETUP_RSP) || (r_state == S_RD_DATA) || (r_state == S_WR_RSP);
    // Only an absent byte counts as waiting: in RD_DATA a byte held off by i_rd_ready is the host's stall.
    assign w_to_hit    = (TIMEOUT_CYCLES != 0) && w_wait && !i_bp_valid && (r_tcnt == TO_LAST);

    assign o_req_ready = (r_state == S_IDLE);
    assign o_done      = r_done;
    assign o_done_data = r_done_data;
    assign o_timeout   = r_timeout;

    always_comb begin
        o_bp_data  = 8'h00;
        o_bp_valid = 1'b0;
        o_bp_ready = 1'b0;
        o_wr_ready = 1'b0;
        o_rd_data  = 8'h00;
        o_rd_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Drain stray responder bytes so a late reply cannot wedge the link.
                o_bp_ready = 1'b1;
            end
            S_SETUP_CMD: begin
                o_bp_data  = 8'h80;
                o_bp_valid = 1'b1;
            end
            S_SETUP_LEN: begin
                o_bp_data  = r_cnt;
                o_bp_valid = 1'b1;
            end
            S_SETUP_RSP, S_WR_RSP: begin
                o_bp_ready = 1'b1;
            end
            S_CMD: begin
                o_bp_data  = {r_wr, r_addr};
                o_bp_valid = 1'b1;
            end
            S_WR_DATA: begin
                o_bp_data  = i_wr_data;
                o_bp_valid = i_wr_valid;
                o_wr_ready = i_bp_ready;
            end
            S_RD_DATA: begin
                o_rd_data  = i_bp_data;
                o_rd_valid = i_bp_valid;
                o_bp_ready = i_rd_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr        <= 1'b0;
            r_addr      <= 7'd0;
            r_cnt       <= 8'd0;
            r_tcnt      <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done_data <= 8'h00;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;

            // Non-wait states hold the counter at zero, so every wait state is entered with a fresh count.
            if (!w_wait || w_bp_in_hs || w_to_hit) begin
                r_tcnt <= '0;
            end else if ((TIMEOUT_CYCLES != 0) && !i_bp_valid) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_wr    <= i_req_wr;
                        r_addr  <= i_req_addr;
                        r_cnt   <= w_le;
                        r_state <= (w_le != 8'd0) ? S_SETUP_CMD : S_CMD;
                    end
                end
                S_SETUP_CMD: begin
                    if (i_bp_ready) r_state <= S_SETUP_LEN;
                end
                S_SETUP_LEN: begin
                    if (i_bp_ready) r_state <= S_SETUP_RSP;
                end
                S_SETUP_RSP: begin
                    if (i_bp_valid) begin
                        r_state <= S_CMD;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_CMD: begin
                    if (i_bp_ready) r_state <= r_wr ? S_WR_DATA : S_RD_DATA;
                end
                S_WR_DATA: begin
                    if (w_bp_out_hs) begin
                        if (r_cnt == 8'd0) r_state <= S_WR_RSP;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end
                end
                S_WR_RSP: begin
                    if (i_bp_valid) begin
                        r_done      <= 1'b1;
                        r_done_data <= i_bp_data;
                        r_state     <= S_IDLE;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_RD_DATA: begin
                    if (w_bp_in_hs) begin
                        if (r_cnt == 8'd0) begin
                            r_done      <= 1'b1;
                            r_done_data <= i_bp_data;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_initiator.sv
`timescale 1ns/1ps
module tb_bp_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid, req_wr;
    logic [6:0] req_addr;
    logic [7:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid, rd_ready;
    logic       bp_ready_in, bp_valid_in;
    logic [7:0] bp_data_in;
    logic       sel_t;   // 1: the TIMEOUT_CYCLES=16 instance is the one under test

    logic       m_req_ready, m_wr_ready, m_rd_valid, m_done, m_timeout, m_bp_valid, m_bp_ready;
    logic [7:0] m_rd_data, m_done_data, m_bp_data;
    logic       t_req_ready, t_wr_ready, t_rd_valid, t_done, t_timeout, t_bp_valid, t_bp_ready;
    logic [7:0] t_rd_data, t_done_data, t_bp_data;
    logic       d_req_ready, d_wr_ready, d_rd_valid, d_done, d_timeout, d_bp_valid, d_bp_ready;
    logic [7:0] d_rd_data, d_done_data, d_bp_data;

    bp_initiator u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid & ~sel_t), .o_req_ready(m_req_ready),
        .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(m_wr_ready),
        .o_rd_data(m_rd_data), .o_rd_valid(m_rd_valid), .i_rd_ready(rd_ready),
        .o_done(m_done), .o_done_data(m_done_data), .o_timeout(m_timeout),
        .o_bp_data(m_bp_data), .o_bp_valid(m_bp_valid), .i_bp_ready(bp_ready_in),
        .i_bp_data(bp_data_in), .i_bp_valid(bp_valid_in), .o_bp_ready(m_bp_ready)
    );

    bp_initiator #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid & sel_t), .o_req_ready(t_req_ready),
        .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(t_wr_ready),
        .o_rd_data(t_rd_data), .o_rd_valid(t_rd_valid), .i_rd_ready(rd_ready),
        .o_done(t_done), .o_done_data(t_done_data), .o_timeout(t_timeout),
        .o_bp_data(t_bp_data), .o_bp_valid(t_bp_valid), .i_bp_ready(bp_ready_in),
        .i_bp_data(bp_data_in), .i_bp_valid(bp_valid_in), .o_bp_ready(t_bp_ready)
    );

    assign d_req_ready = sel_t ? t_req_ready : m_req_ready;
    assign d_wr_ready  = sel_t ? t_wr_ready  : m_wr_ready;
    assign d_rd_data   = sel_t ? t_rd_data   : m_rd_data;
    assign d_rd_valid  = sel_t ? t_rd_valid  : m_rd_valid;
    assign d_done      = sel_t ? t_done      : m_done;
    assign d_done_data = sel_t ? t_done_data : m_done_data;
    assign d_timeout   = sel_t ? t_timeout   : m_timeout;
    assign d_bp_data   = sel_t ? t_bp_data   : m_bp_data;
    assign d_bp_valid  = sel_t ? t_bp_valid  : m_bp_valid;
    assign d_bp_ready  = sel_t ? t_bp_ready  : m_bp_ready;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_done = 0, n_to = 0, n_rd = 0;
    int t_to = 0, t_hs = 0;
    logic [7:0] exp_bp[$], exp_rd[$], exp_done[$], wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pops expectations as the selected DUT produces bytes, read data and completions.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (d_bp_valid && bp_ready_in) begin
                n_tests++;
                if (exp_bp.size() == 0) begin
                    n_fail++; $display("FAIL bp_out: got %02h, expected no byte", d_bp_data);
                end else begin
                    e = exp_bp.pop_front();
                    if (d_bp_data !== e) begin n_fail++; $display("FAIL bp_out: got %02h, expected %02h", d_bp_data, e); end
                end
            end
            if (d_rd_valid && rd_ready) begin
                n_rd++; n_tests++;
                if (exp_rd.size() == 0) begin
                    n_fail++; $display("FAIL rd_data: got %02h, expected no byte", d_rd_data);
                end else begin
                    e = exp_rd.pop_front();
                    if (d_rd_data !== e) begin n_fail++; $display("FAIL rd_data: got %02h, expected %02h", d_rd_data, e); end
                end
            end
            if (d_done) begin
                n_done++; n_tests++;
                if (exp_done.size() == 0) begin
                    n_fail++; $display("FAIL done: unexpected pulse, done_data %02h", d_done_data);
                end else begin
                    e = exp_done.pop_front();
                    if (d_done_data !== e) begin n_fail++; $display("FAIL done_data: got %02h, expected %02h", d_done_data, e); end
                end
                n_tests++;
                if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL req_ready_at_done: got %b, expected 1", d_req_ready); end
            end
            if (d_timeout) begin n_to++; t_to = cyc; end
        end
    end

    task automatic send_req(input logic wr, input logic [6:0] addr, input logic [7:0] len);
        logic [7:0] le;
        logic ok;
        le = (addr == 7'd0) ? 8'd0 : len;
        if (le != 8'd0) begin exp_bp.push_back(8'h80); exp_bp.push_back(le); end
        exp_bp.push_back({wr, addr});
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = d_req_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1; req_valid = 1'b0;
        if (!ok) begin n_tests++; n_fail++; $display("FAIL req_accept: ready 0, expected 1 within 50 cycles"); end
    endtask

    task automatic wr_stream();
        logic [7:0] b;
        logic ok;
        while (wr_q.size() > 0) begin
            b = wr_q.pop_front();
            exp_bp.push_back(b);
            @(posedge clk); #1; wr_valid = 1'b1; wr_data = b;
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk); ok = d_wr_ready;
                if (!ok) begin @(posedge clk); #1; end
            end
            if (!ok) begin n_tests++; n_fail++; $display("FAIL wr_stream: wr_ready 0, expected 1 within 100 cycles"); end
        end
        @(posedge clk); #1; wr_valid = 1'b0;
    endtask

    task automatic sink(input int n, input bit toggle);
        int got;
        logic ph;
        got = 0; ph = 1'b1;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(posedge clk); #1; bp_valid_in = 1'b0;
            bp_ready_in = toggle ? ph : 1'b1; ph = ~ph;
            @(negedge clk);
            if (d_bp_valid && bp_ready_in) begin got++; t_hs = cyc + 1; end
        end
        @(posedge clk); #1; bp_ready_in = 1'b0;
        if (got < n) begin n_tests++; n_fail++; $display("FAIL sink: got %0d bytes, expected %0d", got, n); end
    endtask

    task automatic source(input logic [7:0] b, input int dly, input bit to_rd);
        logic ok;
        @(posedge clk); #1; bp_ready_in = 1'b0; bp_valid_in = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        bp_valid_in = 1'b1; bp_data_in = b;
        if (to_rd) exp_rd.push_back(b);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); ok = d_bp_ready;
            if (!ok) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1; bp_valid_in = 1'b0;
        if (!ok) begin n_tests++; n_fail++; $display("FAIL source: bp_ready 0, expected 1 within 100 cycles"); end
    endtask

    task automatic check_idle_end(input string name, input int d0, input int t0, input int want_done);
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_done - d0 != want_done) begin n_fail++; $display("FAIL %s done_count: got %0d, expected %0d", name, n_done - d0, want_done); end
        n_tests++;
        if (n_to != t0) begin n_fail++; $display("FAIL %s timeout_count: got %0d, expected 0", name, n_to - t0); end
        n_tests++;
        if (exp_bp.size() != 0 || exp_rd.size() != 0) begin
            n_fail++; $display("FAIL %s leftover: got bp %0d rd %0d pending, expected 0", name, exp_bp.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (d_req_ready !== 1'b1 || d_bp_valid !== 1'b0 || d_done !== 1'b0 || d_timeout !== 1'b0 ||
            d_rd_valid !== 1'b0 || d_wr_ready !== 1'b0 || d_done_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got rr%b bv%b dn%b to%b rv%b wr%b dd%02h, expected rr1 bv0 dn0 to0 rv0 wr0 dd00",
                     d_req_ready, d_bp_valid, d_done, d_timeout, d_rd_valid, d_wr_ready, d_done_data);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (d_req_ready !== 1'b1 || d_bp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got rr%b bv%b, expected rr1 bv0", d_req_ready, d_bp_valid);
        end
    endtask

    task automatic test_single_write();
        int d0, t0;
        d0 = n_done; t0 = n_to;
        exp_done.push_back(8'h00);
        wr_q.push_back(8'h05);
        fork
            begin send_req(1'b1, 7'h09, 8'd0); wr_stream(); end
            begin sink(2, 1'b0); source(8'h00, 0, 1'b0); end
        join
        check_idle_end("single_write", d0, t0, 1);
    endtask

    task automatic test_single_read();
        int d0, t0, r0;
        d0 = n_done; t0 = n_to; r0 = n_rd;
        rd_ready = 1'b1;
        exp_done.push_back(8'h20);
        fork
            send_req(1'b0, 7'h04, 8'd0);
            begin sink(1, 1'b0); source(8'h20, 20, 1'b1); end
        join
        check_idle_end("single_read", d0, t0, 1);
        n_tests++;
        if (n_rd - r0 != 1) begin n_fail++; $display("FAIL single_read rd_count: got %0d, expected 1", n_rd - r0); end
    endtask

    task automatic test_burst_write();
        int d0, t0;
        d0 = n_done; t0 = n_to;
        exp_done.push_back(8'h5A);
        wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33); wr_q.push_back(8'h44);
        fork
            begin send_req(1'b1, 7'h0A, 8'd3); wr_stream(); end
            begin sink(2, 1'b1); source(8'h03, 0, 1'b0); sink(5, 1'b1); source(8'h5A, 0, 1'b0); end
        join
        check_idle_end("burst_write", d0, t0, 1);
    endtask

    task automatic test_burst_read();
        int d0, t0, r0;
        logic seen;
        d0 = n_done; t0 = n_to; r0 = n_rd;
        rd_ready = 1'b1;
        exp_done.push_back(8'h33);
        fork
            send_req(1'b0, 7'h01, 8'd2);
            begin
                sink(2, 1'b0); source(8'h02, 0, 1'b0); sink(1, 1'b0);
                source(8'h31, 0, 1'b1); source(8'h32, 0, 1'b1); source(8'h33, 0, 1'b1);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); seen = d_rd_valid && rd_ready; end
                if (!seen) begin n_tests++; n_fail++; $display("FAIL burst_read first_byte: none, expected one within 300 cycles"); end
                @(posedge clk); #1; rd_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    n_tests++;
                    if (d_bp_ready !== 1'b0) begin n_fail++; $display("FAIL burst_read stall_bp_ready: got %b, expected 0", d_bp_ready); end
                    @(posedge clk); #1;
                end
                rd_ready = 1'b1;
            end
        join
        check_idle_end("burst_read", d0, t0, 1);
        n_tests++;
        if (n_rd - r0 != 3) begin n_fail++; $display("FAIL burst_read rd_count: got %0d, expected 3", n_rd - r0); end
    endtask

    task automatic test_addr0_single();
        int d0, t0;
        d0 = n_done; t0 = n_to;
        exp_done.push_back(8'h07);
        wr_q.push_back(8'h07);
        fork
            begin send_req(1'b1, 7'h00, 8'd7); wr_stream(); end
            begin sink(2, 1'b0); source(8'h07, 0, 1'b0); end
        join
        check_idle_end("addr0_single", d0, t0, 1);
    endtask

    task automatic test_back_to_back();
        int d0, t0;
        d0 = n_done; t0 = n_to;
        rd_ready = 1'b1;
        exp_done.push_back(8'h77);
        exp_done.push_back(8'hC3);
        fork
            begin send_req(1'b0, 7'h05, 8'd0); send_req(1'b1, 7'h06, 8'd0); end
            begin
                sink(1, 1'b0); source(8'h77, 2, 1'b1);
                sink(2, 1'b0); source(8'hC3, 3, 1'b0);
            end
            begin wait (exp_bp.size() == 0 && n_done > d0); wr_q.push_back(8'h66); wr_stream(); end
        join
        check_idle_end("back_to_back", d0, t0, 2);
        repeat (5) @(negedge clk);
        n_tests++;
        if (d_done_data !== 8'hC3) begin n_fail++; $display("FAIL done_data_hold: got %02h, expected c3", d_done_data); end
    endtask

    task automatic test_timeout();
        int d0, t0;
        logic seen;
        sel_t = 1'b1;
        d0 = n_done; t0 = n_to;
        fork
            send_req(1'b0, 7'h03, 8'd0);
            sink(1, 1'b0);
        join
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = (n_to > t0); end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL timeout_pulse: none, expected one within 60 cycles");
        end else if (t_to - t_hs != 16) begin
            n_fail++; $display("FAIL timeout_delay: got %0d cycles, expected 16", t_to - t_hs);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_done != d0 || n_to - t0 != 1) begin
            n_fail++; $display("FAIL timeout_counts: got done %0d to %0d, expected done 0 to 1", n_done - d0, n_to - t0);
        end
        n_tests++;
        if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: req_ready %b, expected 1", d_req_ready); end
        sel_t = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int d0;
        d0 = n_done;
        wr_q.push_back(8'hA0); wr_q.push_back(8'hA1);
        fork
            begin send_req(1'b1, 7'h0B, 8'd5); wr_stream(); end
            begin sink(2, 1'b0); source(8'h05, 0, 1'b0); sink(3, 1'b0); end
        join
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 8'hA2; bp_ready_in = 1'b0;
        #1;
        n_tests++;
        if (d_bp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_write_passthru: bp_valid %b, expected 1", d_bp_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (d_bp_valid !== 1'b0 || d_wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_write_reset: bp_valid %b wr_ready %b, expected 0 0", d_bp_valid, d_wr_ready);
        end
        wr_valid = 1'b0;
        exp_bp.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (d_req_ready !== 1'b1 || n_done != d0) begin
            n_fail++; $display("FAIL mid_write_release: req_ready %b done %0d, expected 1 0", d_req_ready, n_done - d0);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 7'd0; req_len = 8'd0;
        wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0;
        bp_ready_in = 1'b0; bp_valid_in = 1'b0; bp_data_in = 8'h00;
        sel_t = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_burst_read();
        test_addr0_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at 400us, expected completion");
        $fatal(1);
    end

endmodule
